// File: rtl/lifo_pkg.sv
// lifo_pkg: shared data width and drain FSM state encoding for the LIFO read side.
package lifo_pkg;
  localparam int DATA_WIDTH = 8;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/lifo_drain.sv
// lifo_drain: pops up to count words from the LIFO and streams them out on valid/ready.
module lifo_drain
  import lifo_pkg::*;
#(
  parameter int WIDTH   = DATA_WIDTH,
  parameter int COUNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  output logic               underflow,
  output logic [COUNT_W-1:0] popped,
  output logic               lifo_rd_en,
  input  logic [WIDTH-1:0]   lifo_rd_data,
  input  logic               lifo_empty,
  input  logic               lifo_error,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready
);
  state_t             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] popped_q, popped_d;
  logic               underflow_q, underflow_d;
  logic [WIDTH-1:0]   m_data_q, m_data_d;
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    popped_d    = popped_q;
    underflow_d = underflow_q;
    m_data_d    = m_data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d     = (count == '0) ? DONE : POP;
        remaining_d = count;
        popped_d    = '0;
        underflow_d = 1'b0;
      end
      POP: begin
        state_d     = lifo_empty ? DONE : WAIT;
        underflow_d = underflow_q | lifo_empty;
      end
      WAIT: if (lifo_error) begin
        state_d     = DONE;
        underflow_d = 1'b1;
      end else begin
        state_d     = HOLD;
        m_data_d    = lifo_rd_data;
        remaining_d = remaining_q - 1'b1;
      end
      HOLD: if (m_ready) begin
        state_d  = (remaining_q != '0) ? POP : DONE;
        popped_d = popped_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      popped_q    <= '0;
      underflow_q <= 1'b0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      popped_q    <= popped_d;
      underflow_q <= underflow_d;
      m_data_q    <= m_data_d;
    end
  end
  // Pop strobe is gated by empty so an exhausted stack is never read.
  assign lifo_rd_en = (state_q == POP) && !lifo_empty;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign m_valid    = state_q == HOLD;
  assign m_data     = m_data_q;
  assign popped     = popped_q;
  assign underflow  = underflow_q;
endmodule

// File: doc/lifo_drain.md
# lifo_drain

Read-side controller for the team's 8-bit LIFO. On a start command it pops up to a requested number of words, one at a time, and presents each on a valid/ready output stream, stopping early and flagging underflow if the stack runs dry. It sits between the LIFO's read port and any downstream consumer. It is the counterpart to the push-side stimulus that loads the stack.

## Interface
- WIDTH, 8: data word width; matches the LIFO data width.
- COUNT_W, 5: width of the burst-length and popped-count fields. Bursts of up to 2^COUNT_W-1 words are supported.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a drain burst; sampled only in IDLE.
- count  in  COUNT_W  words to pop; captured with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a burst ends.
- underflow  out  1  sticky; set when the burst ends short. Cleared by the next accepted start or by rst.
- popped  out  COUNT_W  words delivered in the current or last burst.
- lifo_rd_en  out  1  one-cycle pop strobe. Top level drives LIFO read_write_bar=1 while this is high.
- lifo_rd_data  in  WIDTH  LIFO read_data.
- lifo_empty  in  1  LIFO empty flag.
- lifo_error  in  1  LIFO error flag.
- m_data  out  WIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready at a clock edge.

## Operation
- States: IDLE, POP, WAIT, HOLD, DONE.
- IDLE
  - start=1 with count=0 -> DONE. No pop is issued.
  - start=1 with count>0 -> latch remaining=count, clear popped and underflow, go to POP.
  - start is ignored in every state except IDLE.
- POP
  - lifo_empty=0: lifo_rd_en=1 for exactly this cycle, then WAIT.
  - lifo_empty=1: lifo_rd_en stays 0, underflow is set, then DONE.
- WAIT: data from the LIFO is valid this cycle.
  - lifo_error=1: discard the data, set underflow, go to DONE.
  - Otherwise: m_data<=lifo_rd_data, remaining decrements, go to HOLD.
- HOLD: m_valid=1 and m_data is held stable.
  - On handshake, popped increments.
  - Then: remaining>0 -> POP; remaining=0 -> DONE.
  - Without a handshake, stay in HOLD. No pops are issued while in HOLD.
- DONE: done=1 for one cycle, then IDLE.
- lifo_rd_en is asserted only in POP, so at most one pop is outstanding at any time.
- Pop order is LIFO order, so the last word pushed is the first word delivered.
- Counters are unsigned and never wrap, because remaining never exceeds the captured count.

## Timing
- Reset values: busy=0, done=0, underflow=0, popped=0, lifo_rd_en=0, m_valid=0, m_data=0. State is IDLE.
- Reset mid-burst takes effect at the next edge: every output returns to its reset value, and a word held in HOLD is dropped.
- Burst start
  - start high at edge E -> lifo_rd_en high in cycle E+1.
  - LIFO data is captured at edge E+3, and m_valid is high from cycle E+3.
- Pipelined pops
  - Handshake at edge H -> next lifo_rd_en in cycle H+1.
  - Peak throughput is one word per 3 cycles.
- Burst end
  - Last handshake at edge H -> done pulse in cycle H+1 -> busy=0 in cycle H+2.
  - count=0: done is high in the cycle after start, with no lifo_rd_en.
- lifo_empty is sampled in POP only; changes in other states have no effect.
- done and underflow are valid in the same cycle. popped is final when done is high.

## Structure
- Shared package lifo_pkg holds:
  - WIDTH default;
  - the state encoding (IDLE=0, POP=1, WAIT=2, HOLD=3, DONE=4).
- Single flat module with no sub-module; the output register is part of the FSM datapath.

## Test plan
- Push 0..14 into the LIFO, start count=15 with m_ready=1 -> m_data 14,13,…,0, popped=15, underflow=0, one done pulse.
- Same preload, start count=20 -> 15 words 14..0, then underflow=1, popped=15, done. No lifo_rd_en is issued while lifo_empty=1.
- start count=0 -> done in the next cycle, lifo_rd_en never high, popped=0.
- Backpressure: m_ready=0 for 5 cycles while in HOLD with m_data=14 -> m_data stays 14, m_valid stays 1, no lifo_rd_en. Release m_ready -> next word 13.
- start pulsed while busy -> ignored; popped and the burst length are unchanged.
- rst=1 after the 4th handshake -> next cycle all outputs are 0 and the FSM is in IDLE. A new start count=3 drains 10,9,8.
